// File: rtl/tt_scan_pkg.sv
// Shared types and defaults for the scan load/capture/unload controller.
package tt_scan_pkg;

  localparam int DEF_CHAIN_LEN = 4;
  localparam int DEF_CAP_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } scan_state_e;

  // One counter serves every phase, so it must hold both the chain length and the capture count.
  function automatic int cnt_width(input int chain_len, input int cap_w);
    return ($clog2(chain_len + 1) > cap_w) ? $clog2(chain_len + 1) : cap_w;
  endfunction

endpackage

// File: rtl/tt_scan_cnt.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module tt_scan_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk_gen,
  input  logic         i_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tt_scan_ctrl.sv
// Scan sequencer: shift a pattern in, run functional capture cycles, shift the chain out.
//   state   | meaning
//   IDLE    | waiting for i_start, scan disabled
//   LOAD    | shifting pattern MSB first, scan_en high
//   CAPTURE | latched number of functional cycles, scan_en low
//   UNLOAD  | shifting chain out (zeros in), sampling i_scan_out
//   DONE    | one-cycle o_done with o_result updated
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CAP_W     = DEF_CAP_W
) (
  input  logic                 i_clk_gen,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CHAIN_LEN-1:0] i_pattern,
  input  logic [CAP_W-1:0]     i_cap_cycles,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CHAIN_LEN-1:0] o_result,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  input  logic                 i_scan_out
);

  localparam int CNT_W = cnt_width(CHAIN_LEN, CAP_W);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_e state, state_d;

  logic [CHAIN_LEN-1:0] pat_sr, pat_d;
  logic [CHAIN_LEN-1:0] unl_sr, unl_d;
  logic [CHAIN_LEN-1:0] result_d;
  logic [CAP_W-1:0]     cap_q, cap_d;
  logic                 scan_en_d, scan_in_d, busy_d, done_d;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]     cnt_val;

  // Counter is loaded with (phase length - 1); zero marks the last cycle of a phase.
  tt_scan_cnt #(.W(CNT_W)) u_cnt (
    .i_clk_gen (i_clk_gen),
    .i_rst     (i_rst),
    .load      (cnt_load),
    .load_val  (cnt_val),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  always_comb begin
    state_d   = state;
    pat_d     = pat_sr;
    unl_d     = unl_sr;
    result_d  = o_result;
    cap_d     = cap_q;
    scan_en_d = 1'b0;
    scan_in_d = 1'b0;
    busy_d    = o_busy;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          state_d   = ST_LOAD;
          pat_d     = i_pattern << 1;
          cap_d     = i_cap_cycles;
          scan_en_d = 1'b1;
          scan_in_d = i_pattern[CHAIN_LEN-1];
          busy_d    = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = SHIFT_LAST;
        end
      end
      ST_LOAD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (cap_q == '0) begin
            state_d   = ST_UNLOAD;
            cnt_val   = SHIFT_LAST;
            scan_en_d = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
            cnt_val = CNT_W'(cap_q) - CNT_W'(1);
          end
        end else begin
          cnt_dec   = 1'b1;
          scan_en_d = 1'b1;
          scan_in_d = pat_sr[CHAIN_LEN-1];
          pat_d     = pat_sr << 1;
        end
      end
      ST_CAPTURE: begin
        if (cnt_zero) begin
          state_d   = ST_UNLOAD;
          cnt_load  = 1'b1;
          cnt_val   = SHIFT_LAST;
          scan_en_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_UNLOAD: begin
        // First sample ends up in the MSB after CHAIN_LEN shifts.
        unl_d = (unl_sr << 1) | CHAIN_LEN'(i_scan_out);
        if (cnt_zero) begin
          state_d  = ST_DONE;
          result_d = unl_d;
          done_d   = 1'b1;
        end else begin
          cnt_dec   = 1'b1;
          scan_en_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      pat_sr    <= '0;
      unl_sr    <= '0;
      cap_q     <= '0;
      o_result  <= '0;
      o_scan_en <= 1'b0;
      o_scan_in <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_d;
      pat_sr    <= pat_d;
      unl_sr    <= unl_d;
      cap_q     <= cap_d;
      o_result  <= result_d;
      o_scan_en <= scan_en_d;
      o_scan_in <= scan_in_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Self-checking bench for tt_scan_ctrl against a 4-flop target chain model.
module tb_tt_scan_ctrl;

  localparam int N = 4;

  logic         i_clk_gen = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic [N-1:0] i_pattern = '0;
  logic [3:0]   i_cap_cycles = '0;
  logic         o_busy, o_done, o_scan_en, o_scan_in;
  logic [N-1:0] o_result;
  logic         i_scan_out;

  int checks = 0;
  int failures = 0;

  tt_scan_ctrl #(.CHAIN_LEN(N), .CAP_W(4)) dut (
    .i_clk_gen    (i_clk_gen),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_pattern    (i_pattern),
    .i_cap_cycles (i_cap_cycles),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_scan_en    (o_scan_en),
    .o_scan_in    (o_scan_in),
    .i_scan_out   (i_scan_out)
  );

  always #5 i_clk_gen = ~i_clk_gen;

  // Target chain: shifts when scan-enabled, otherwise holds or increments.
  logic [N-1:0] tgt_sr = '0;
  bit           tgt_inc = 1'b0;
  always @(posedge i_clk_gen) begin
    if (o_scan_en) tgt_sr <= {tgt_sr[N-2:0], o_scan_in};
    else if (tgt_inc) tgt_sr <= tgt_sr + 1'b1;
  end
  assign i_scan_out = tgt_sr[N-1];

  logic [N-1:0] sb_q[$];
  logic [N-1:0] last_result = '0;

  typedef struct {
    logic [3:0] pat;
    logic [3:0] cap;
    bit         inc;
    logic [3:0] exp_res;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk_gen);
    #1;
  endtask

  // Drives one sequence from the current (idle) cycle; returns in the cycle after DONE.
  task automatic run_seq(input logic [3:0] pat, input logic [3:0] cap, input bit inc,
                         input logic [3:0] exp_res, input int exp_done, input bit glitch);
    int k, c, done_cyc, prof_err, busy_err, hold_err;
    logic [N-1:0] loaded, got;
    bit exp_en;
    c = int'(cap);
    done_cyc = 0; prof_err = 0; busy_err = 0; hold_err = 0; loaded = '0;
    tgt_inc = inc;
    i_pattern = pat; i_cap_cycles = cap; i_start = 1'b1;
    sb_q.push_back(exp_res);
    step();
    i_start = 1'b0; i_pattern = ~pat; i_cap_cycles = 4'hF;
    k = 1;
    while (done_cyc == 0 && k <= 60) begin
      exp_en = (k <= N) || (k >= N + c + 1 && k <= 2 * N + c);
      if (o_scan_en !== exp_en) prof_err++;
      if (k > N + c && o_scan_in !== 1'b0) prof_err++;
      if (k <= N) loaded = {loaded[N-2:0], o_scan_in};
      if (o_busy !== 1'b1) busy_err++;
      if (o_done === 1'b1) begin
        done_cyc = k;
        chk("done_cycle", done_cyc, exp_done);
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          got = sb_q.pop_front();
          chk("result", o_result, got);
          last_result = got;
        end
      end else if (o_result !== last_result) begin
        hold_err++;
      end
      i_start = glitch && (k == 3 || k == 9);
      step();
      k++;
    end
    i_start = 1'b0;
    if (done_cyc == 0) begin
      chk("done_timeout", 0, 1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    chk("load_bits", loaded, pat);
    chk("scan_profile_errs", prof_err, 0);
    chk("busy_errs", busy_err, 0);
    chk("result_hold_errs", hold_err, 0);
    chk("post_done_low", {o_done, o_busy, o_scan_en}, 3'b000);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{4'b1011, 4'h0, 1'b0, 4'b1011, 9};
    vecs[1] = '{4'b0010, 4'h3, 1'b1, 4'b0101, 12};
    vecs[2] = '{4'b1111, 4'hF, 1'b0, 4'b1111, 24};
    vecs[3] = '{4'b0110, 4'h0, 1'b0, 4'b0110, 9};
    vecs[4] = '{4'b0001, 4'h1, 1'b1, 4'b0010, 10};
    vecs[5] = '{4'b1110, 4'h2, 1'b1, 4'b0000, 11};
    vecs[6] = '{4'b0101, 4'h5, 1'b0, 4'b0101, 14};

    // Reset with a simultaneous start request.
    i_start = 1'b1; i_pattern = 4'b1010; i_cap_cycles = 4'h2;
    repeat (3) step();
    i_rst = 1'b0; i_start = 1'b0;
    chk("reset_outputs", {o_busy, o_done, o_scan_en, o_scan_in}, 4'b0000);
    chk("reset_result", o_result, 4'b0000);
    step();
    chk("start_with_reset_ignored", {o_busy, o_scan_en}, 2'b00);

    foreach (vecs[i])
      run_seq(vecs[i].pat, vecs[i].cap, vecs[i].inc, vecs[i].exp_res, vecs[i].exp_done, 1'b0);

    // Start pulses mid-sequence are ignored.
    step();
    run_seq(4'b1100, 4'h2, 1'b0, 4'b1100, 11, 1'b1);
    done_seen = 0;
    repeat (6) begin
      if (o_done === 1'b1 || o_busy === 1'b1) done_seen++;
      step();
    end
    chk("no_extra_seq_after_glitch", done_seen, 0);
    run_seq(4'b0011, 4'h0, 1'b1, 4'b0011, 9, 1'b0);

    // Reset in cycle 6 (capture phase) aborts the sequence.
    tgt_inc = 1'b0;
    i_pattern = 4'b1011; i_cap_cycles = 4'h3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) i_rst = 1'b1;
      step();
    end
    i_rst = 1'b0;
    chk("abort_outputs", {o_busy, o_done, o_scan_en}, 3'b000);
    chk("abort_result", o_result, 4'b0000);
    done_seen = 0;
    repeat (15) begin
      if (o_done === 1'b1 || o_scan_en === 1'b1) done_seen++;
      step();
    end
    chk("abort_no_done", done_seen, 0);
    last_result = '0;

    // Back-to-back: second start lands in the IDLE cycle right after DONE.
    run_seq(4'b1011, 4'h0, 1'b0, 4'b1011, 9, 1'b0);
    run_seq(4'b0110, 4'h0, 1'b0, 4'b0110, 9, 1'b0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_scan_ctrl.md
TT_SCAN_CTRL -- requirements
Module: tt_scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 4: number of scan flops in the target chain.
REQ-002 SHALL have parameter CAP_W, default 4: width of the capture-cycle count.
REQ-003 SHALL have port i_clk_gen  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  request one load/capture/unload sequence.
REQ-006 SHALL have port i_pattern  input  CHAIN_LEN  pattern to load, sampled with i_start.
REQ-007 SHALL have port i_cap_cycles  input  CAP_W  functional cycles between load and unload, sampled with i_start.
REQ-008 SHALL have port o_busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse when o_result is valid.
REQ-010 SHALL have port o_result  output  CHAIN_LEN  unloaded chain contents.
REQ-011 SHALL have port o_scan_en  output  1  scan-enable to the target chain.
REQ-012 SHALL have port o_scan_in  output  1  serial data into the target chain.
REQ-013 SHALL have port i_scan_out  input  1  serial data from the target chain.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CAPTURE, UNLOAD, DONE; all outputs registered.
REQ-015 IDLE: o_scan_en=0, o_busy=0; i_start=1 latches i_pattern and i_cap_cycles and moves to LOAD.
REQ-016 i_start SHALL be ignored in every state other than IDLE; latched values SHALL NOT change mid-sequence.
REQ-017 LOAD: o_scan_en=1 for exactly CHAIN_LEN cycles; o_scan_in drives the pattern MSB first (bit CHAIN_LEN-1 in the first cycle, bit 0 in the last).
REQ-018 CAPTURE: o_scan_en=0 for exactly i_cap_cycles cycles; i_cap_cycles=0 SHALL skip CAPTURE (LOAD goes straight to UNLOAD).
REQ-019 UNLOAD: o_scan_en=1 for exactly CHAIN_LEN cycles with o_scan_in=0; on each such rising edge i_scan_out is sampled before the shift; the k-th sample (k=0 first) goes to o_result[CHAIN_LEN-1-k].
REQ-020 DONE: one cycle, o_scan_en=0, o_done=1, o_result updated; next state IDLE; i_start in DONE is ignored.
REQ-021 Timing with start accepted at edge 0, N=CHAIN_LEN, C=i_cap_cycles: o_scan_en high cycles 1..N and N+C+1..2N+C; o_done in cycle 2N+C+1.
REQ-022 o_result SHALL hold its value from DONE until the next DONE.
REQ-023 Counters SHALL be sized max($clog2(CHAIN_LEN+1), CAP_W); i_cap_cycles all-ones SHALL yield 2^CAP_W-1 cycles with no wrap.

Reset
REQ-024 i_rst=1 at a rising edge SHALL force IDLE, o_scan_en=0, o_scan_in=0, o_busy=0, o_done=0, o_result=0, counters=0.
REQ-025 Reset mid-sequence SHALL abort with no o_done pulse; o_scan_en low in the first cycle after reset.
REQ-026 i_start asserted together with i_rst SHALL be ignored.

Structure
REQ-027 Package tt_scan_pkg SHALL hold the state enum and the default CHAIN_LEN/CAP_W constants.
REQ-028 One sub-module, tt_scan_cnt (loadable down-counter with zero flag), SHALL be used for LOAD, CAPTURE and UNLOAD.

Verification (bench target model: CHAIN_LEN-bit shift register sr<={sr[CHAIN_LEN-2:0],in} when scan_en, output sr[MSB])
REQ-029 Hold-mode target, pattern 4'b1011, cap 0 -> o_result 4'b1011, o_done at cycle 9, o_scan_en high cycles 1-8.
REQ-030 Target increments sr each non-scan cycle, pattern 4'b0010, cap 3 -> o_result 4'b0101, o_done at cycle 12.
REQ-031 i_start pulsed in cycles 3 and 9 of a running sequence -> no effect; single o_done; next start in IDLE accepted.
REQ-032 i_rst asserted in cycle 6 (CAPTURE) -> o_scan_en=0, o_busy=0 next cycle, no o_done, o_result 0.
REQ-033 Cap 4'hF, pattern 4'b1111, hold target -> 15 capture cycles, o_done at cycle 24, o_result 4'b1111.
REQ-034 Back-to-back: start in the cycle after DONE with pattern 4'b0110 -> accepted; o_result changes only at the second DONE.
